mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/scd_mem_pkg.sv | 19 +
 rtl/mem_lane_merge.sv | 21 ++
 rtl/mem_access_sequencer.sv | 143 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scd_mem_pkg.sv
// Shared definitions for the memory access sequencer.
// Provides the FSM state encoding, access-size encoding and the legal
// bounds of the read-latency parameter.
package scd_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR      = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_HALF = 1'b1;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 3;

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane helper for a 16-bit word memory (purely combinational).
// Ports:
//   word       - word read from memory
//   byte_sel   - address bit 0: 0 selects [7:0], 1 selects [15:8]
//   wdata_byte - byte to be stored
//   rd_byte    - selected byte of word, zero-extended
//   merged     - word with the selected lane replaced by wdata_byte
module mem_lane_merge
   import scd_mem_pkg::*;
(
   input  logic [15:0] word,
   input  logic        byte_sel,
   input  logic [7:0]  wdata_byte,
   output logic [15:0] rd_byte,
   output logic [15:0] merged
);

   assign rd_byte = byte_sel ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
   assign merged  = byte_sel ? {wdata_byte, word[7:0]} : {word[15:8], wdata_byte};

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences byte/halfword loads and stores onto a 16-bit word memory with
// a synchronous read of READ_LATENCY cycles. Byte stores are done as
// read-modify-write; misaligned halfwords are rejected with rsp_err.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// RD_WAIT | word address on mem_addr, counting down read latency
// WR      | one-cycle mem_we pulse with the full word
// RESP    | response held until rsp_ready
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake
//   req_we, req_byte_half        - store/load, halfword/byte
//   req_addr, req_wdata          - byte address, store data
//   rsp_valid/rsp_ready          - response handshake
//   rsp_rdata, rsp_err           - load data, misaligned flag
//   mem_addr, mem_we, mem_wdata  - word memory write/address port
//   mem_rdata                    - word memory read data
module mem_access_sequencer
   import scd_mem_pkg::*;
#(
   parameter int READ_LATENCY = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte_half,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [14:0] mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   // Out-of-range values are clamped so the counter width stays valid.
   localparam int RL_EFF = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                           READ_LATENCY;
   localparam logic [1:0] CNT_LOAD = 2'(RL_EFF - 1);

   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic        cap_we;
   logic        cap_half;
   logic [15:0] cap_addr;
   logic [15:0] cap_wdata;
   logic [15:0] wr_word;
   logic [15:0] rdata_q;
   logic        err_q;
   logic        accept;
   logic        misaligned;
   logic [15:0] lane_rdata;
   logic [15:0] lane_merged;

   assign accept     = req_valid && (state == ST_IDLE);
   assign misaligned = (req_byte_half == SIZE_HALF) && req_addr[0];

   mem_lane_merge u_lane (
      .word       (mem_rdata),
      .byte_sel   (cap_addr[0]),
      .wdata_byte (cap_wdata[7:0]),
      .rd_byte    (lane_rdata),
      .merged     (lane_merged)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (misaligned)
                  state_nxt = ST_RESP;
               else if (req_we && (req_byte_half == SIZE_HALF))
                  state_nxt = ST_WR;
               else
                  state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (cnt == 2'd0)
               state_nxt = cap_we ? ST_WR : ST_RESP;
         end
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 2'd0;
         cap_we    <= 1'b0;
         cap_half  <= SIZE_BYTE;
         cap_addr  <= 16'h0000;
         cap_wdata <= 16'h0000;
         wr_word   <= 16'h0000;
         rdata_q   <= 16'h0000;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cap_we    <= req_we;
            cap_half  <= req_byte_half;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            err_q     <= misaligned;
            rdata_q   <= 16'h0000;
            if (req_we && (req_byte_half == SIZE_HALF))
               wr_word <= req_wdata;
         end else if (state == ST_RD_WAIT) begin
            if (cnt != 2'd0)
               cnt <= cnt - 2'd1;
            else if (cap_we)
               wr_word <= lane_merged;
            else
               rdata_q <= (cap_half == SIZE_HALF) ? mem_rdata : lane_rdata;
         end
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_addr  = cap_addr[15:1];
   assign mem_we    = (state == ST_WR);
   assign mem_wdata = wr_word;

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we [2];
   logic        req_byte_half [2];
   logic [15:0] req_addr [2];
   logic [15:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [15:0] rsp_rdata [2];
   logic        rsp_err [2];
   logic [14:0] mem_addr [2];
   logic        mem_we [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];

   logic [15:0] mem [2][256];
   logic [15:0] ref_mem [2][256];
   logic [15:0] pipe_a, pipe_b;
   int          we_count [2];
   logic [14:0] last_waddr [2];
   logic [15:0] last_wdata [2];
   logic        pre_en;
   logic [7:0]  pre_idx;
   logic [15:0] pre_data;

   int passes = 0;
   int total  = 0;

   // Instance 0 has READ_LATENCY=1, instance 1 has READ_LATENCY=3.
   mem_access_sequencer #(.READ_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_byte_half(req_byte_half[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   mem_access_sequencer #(.READ_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_byte_half(req_byte_half[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   // Word memories: latency 1 is a read of the presented address within the
   // cycle, latency 3 adds two register stages after that.
   assign mem_rdata[0] = mem[0][mem_addr[0][7:0]];
   assign mem_rdata[1] = pipe_b;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[0][pre_idx] <= pre_data;
         mem[1][pre_idx] <= pre_data;
      end
      for (int d = 0; d < 2; d++) begin
         if (mem_we[d] === 1'b1) begin
            mem[d][mem_addr[d][7:0]] <= mem_wdata[d];
            we_count[d]   <= we_count[d] + 1;
            last_waddr[d] <= mem_addr[d];
            last_wdata[d] <= mem_wdata[d];
         end
      end
      pipe_a <= mem[1][mem_addr[1][7:0]];
      pipe_b <= pipe_a;
   end

   task automatic preload(input logic [7:0] idx, input logic [15:0] val);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = idx;
      pre_data = val;
      ref_mem[0][idx] = val;
      ref_mem[1][idx] = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // One full transaction on instance d, checked against the reference memory.
   task automatic do_txn(input int d, input string name, input logic we, input logic half,
                         input logic [15:0] addr, input logic [15:0] wdata, input int hold);
      logic        err;
      logic [15:0] word, exp_rdata, new_word;
      int          exp_lat, lat, n, base, exp_we, rl;
      logic        ready_seen, unstable;

      rl        = (d == 0) ? 1 : 3;
      err       = half && addr[0];
      word      = ref_mem[d][addr[8:1]];
      exp_rdata = 16'h0000;
      new_word  = word;
      if (!err) begin
         if (!we)
            exp_rdata = half ? word : (addr[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]});
         else
            new_word = half ? wdata : (addr[0] ? {wdata[7:0], word[7:0]} : {word[15:8], wdata[7:0]});
      end
      exp_lat = err ? 1 : (we && half) ? 2 : (!we) ? rl + 1 : rl + 2;
      exp_we  = (we && !err) ? 1 : 0;

      @(negedge clk);
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (req_ready[d] !== 1'b1) $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready[d]);
      else passes++;

      base             = we_count[d];
      req_valid[d]     = 1'b1;
      req_we[d]        = we;
      req_byte_half[d] = half;
      req_addr[d]      = addr;
      req_wdata[d]     = wdata;
      rsp_ready[d]     = (hold == 0);
      @(posedge clk);
      // Garbage requests while busy must be ignored.
      #1;
      req_we[d]        = 1'($urandom);
      req_byte_half[d] = 1'($urandom);
      req_addr[d]      = 16'($urandom);
      req_wdata[d]     = 16'($urandom);

      lat = 0;
      ready_seen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (req_ready[d] === 1'b1) ready_seen = 1'b1;
      end while (rsp_valid[d] !== 1'b1 && lat < 12);
      req_valid[d] = 1'b0;

      total++;
      if (lat !== exp_lat || rsp_valid[d] !== 1'b1)
         $display("FAIL %s rsp latency: got %0d (valid=%b) want %0d", name, lat, rsp_valid[d], exp_lat);
      else passes++;
      total++;
      if (ready_seen !== 1'b0) $display("FAIL %s req_ready while busy: got 1 want 0", name);
      else passes++;
      total++;
      if (rsp_err[d] !== err) $display("FAIL %s rsp_err: got %b want %b", name, rsp_err[d], err);
      else passes++;
      total++;
      if (rsp_rdata[d] !== exp_rdata) $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata[d], exp_rdata);
      else passes++;

      unstable = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (rsp_valid[d] !== 1'b1 || rsp_err[d] !== err || rsp_rdata[d] !== exp_rdata || req_ready[d] !== 1'b0)
            unstable = 1'b1;
      end
      if (hold > 0) begin
         total++;
         if (unstable !== 1'b0) $display("FAIL %s rsp held during backpressure: got unstable want stable", name);
         else passes++;
      end

      rsp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1)
         $display("FAIL %s after handshake: got valid=%b ready=%b want valid=0 ready=1", name, rsp_valid[d], req_ready[d]);
      else passes++;

      total++;
      if (we_count[d] - base !== exp_we)
         $display("FAIL %s mem_we pulses: got %0d want %0d", name, we_count[d] - base, exp_we);
      else passes++;
      if (exp_we == 1) begin
         total++;
         if (last_waddr[d] !== addr[15:1] || last_wdata[d] !== new_word)
            $display("FAIL %s mem write: got addr=%h data=%h want addr=%h data=%h",
                     name, last_waddr[d], last_wdata[d], addr[15:1], new_word);
         else passes++;
      end
      ref_mem[d][addr[8:1]] = new_word;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pre_en = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_byte_half[d] = 1'b0;
         req_addr[d] = 16'h0; req_wdata[d] = 16'h0; rsp_ready[d] = 1'b1;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 16'h0)
            $display("FAIL reset rsp[%0d]: got v=%b e=%b d=%h want 0/0/0000", d, rsp_valid[d], rsp_err[d], rsp_rdata[d]);
         else passes++;
         total++;
         if (mem_we[d] !== 1'b0 || mem_addr[d] !== 15'h0 || mem_wdata[d] !== 16'h0)
            $display("FAIL reset mem[%0d]: got we=%b a=%h d=%h want 0/0/0", d, mem_we[d], mem_addr[d], mem_wdata[d]);
         else passes++;
      end
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (req_ready[d] !== 1'b1) $display("FAIL reset req_ready[%0d]: got %b want 1", d, req_ready[d]);
         else passes++;
      end
      for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));
   endtask

   task automatic test_directed();
      preload(8'h08, 16'hBEEF);
      do_txn(0, "load_half_rl1", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
      preload(8'h08, 16'h1234);
      do_txn(0, "byte_store_odd", 1'b1, 1'b0, 16'h0011, 16'h00AA, 0);
      preload(8'h10, 16'h5A3C);
      do_txn(1, "byte_load_rl3", 1'b0, 1'b0, 16'h0021, 16'h0000, 0);
      do_txn(0, "misaligned_store", 1'b1, 1'b1, 16'h0003, 16'h7777, 0);
      do_txn(0, "half_store_hold5", 1'b1, 1'b1, 16'h0004, 16'hCAFE, 5);
      do_txn(0, "half_readback", 1'b0, 1'b1, 16'h0004, 16'h0000, 0);
      do_txn(1, "byte_store_even_rl3", 1'b1, 1'b0, 16'h0040, 16'h0055, 2);
      do_txn(1, "misaligned_load_rl3", 1'b0, 1'b1, 16'h0041, 16'h0000, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         do_txn(int'($urandom_range(0, 1)), "random", 1'($urandom), 1'($urandom),
                16'($urandom_range(0, 511)), 16'($urandom), int'($urandom_range(0, 2)));
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         do_txn(0, "back_to_back", 1'(i % 2), 1'($urandom), 16'($urandom_range(0, 63) * 2),
                16'($urandom), 0);
   endtask

   task automatic test_reset_in_wr();
      int          base;
      logic        bad;
      logic [15:0] old;
      old  = ref_mem[0][8'h08];
      base = we_count[0];
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_byte_half[0] = 1'b0;
      req_addr[0] = 16'h0011; req_wdata[0] = 16'h0066; rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (mem_we[0] !== 1'b1) $display("FAIL rst_in_wr reach WR: got mem_we=%b want 1", mem_we[0]);
      else passes++;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (mem_we[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
         $display("FAIL rst_in_wr after reset: got we=%b v=%b rdy=%b want 0/0/1", mem_we[0], rsp_valid[0], req_ready[0]);
      else passes++;
      bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_we[0] !== 1'b0 || rsp_valid[0] !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad !== 1'b0) $display("FAIL rst_in_wr aborted: got late mem_we/rsp want none");
      else passes++;
      total++;
      if (we_count[0] - base !== 1) $display("FAIL rst_in_wr pulses: got %0d want 1", we_count[0] - base);
      else passes++;
      // The write strobe was visible at the reset edge, so the memory took it.
      ref_mem[0][8'h08] = {8'h66, old[7:0]};
      ref_mem[1][8'h08] = ref_mem[1][8'h08];
      do_txn(0, "after_abort_load", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_in_wr();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
